ntt_job_scheduler: RTL and testbench
====================================

NTT_JOB_SCHEDULER -- requirements
Module: ntt_job_scheduler

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: job queue depth, power of two, at least 2.
REQ-002 Parameter MAX_MOD_IDX, default 59: highest legal modulus index, so that mod_idx*34 fits 11 bits.
REQ-003 Parameter START_TIMEOUT, default 4: cycles allowed for ctrl_done to fall after ctrl_start.
REQ-004 Port clk, input, 1: clock; all logic on rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port req_valid, input, 1: job request valid.
REQ-007 Port req_ready, output, 1: queue can accept a job.
REQ-008 Port req_mod_idx, input, 6: modulus index of the job.
REQ-009 Port req_tag, input, 4: opaque job tag, returned with the response.
REQ-010 Port ctrl_start, output, 1: one-cycle start pulse to the NTT controller.
REQ-011 Port ctrl_mod_idx, output, 6: modulus index driven to the NTT controller.
REQ-012 Port ctrl_done, input, 1: controller idle level; high means IDLE.
REQ-013 Port rsp_valid, output, 1: completion valid.
REQ-014 Port rsp_ready, input, 1: completion accepted.
REQ-015 Port rsp_tag, output, 4: tag of the completed job.
REQ-016 Port rsp_err, output, 1: set when mod_idx was illegal or the start timed out.
REQ-017 Port rsp_cycles, output, 20: job runtime in cycles, saturating.
REQ-018 Port busy, output, 1: high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-019 Queue: FIFO of {tag, mod_idx}; push on req_valid&&req_ready; req_ready = !full; pointers wrap modulo FIFO_DEPTH.
REQ-020 Full queue: no push; pop and push in the same cycle are permitted only when the queue is not full.
REQ-021 FSM states: IDLE, LAUNCH, WAIT_BUSY, RUN, RESPOND.
REQ-022 IDLE with queue non-empty, ctrl_done=1, and head mod_idx>MAX_MOD_IDX: pop the head, set err, go to RESPOND; ctrl_start is not asserted.
REQ-023 IDLE with queue non-empty, ctrl_done=1, and legal head: pop the head, register tag and mod_idx, clear the counter, go to LAUNCH.
REQ-024 IDLE with ctrl_done=0: no dispatch; wait.
REQ-025 LAUNCH: ctrl_start=1 for exactly this cycle; go to WAIT_BUSY.
REQ-026 WAIT_BUSY: when ctrl_done=0, go to RUN; if ctrl_done has stayed 1 for START_TIMEOUT cycles, set err and go to RESPOND.
REQ-027 RUN: when ctrl_done=1, go to RESPOND.
REQ-028 Counter: increments every cycle in LAUNCH, WAIT_BUSY and RUN; saturates at 2^20-1; rsp_cycles is the value on entry to RESPOND.
REQ-029 RESPOND: rsp_valid=1, rsp_* held stable until rsp_ready; on handshake, clear err and go to IDLE.
REQ-030 ctrl_mod_idx is registered, loaded on dispatch, and held constant until the next dispatch.
REQ-031 Latency: push at cycle T into an empty queue, with FSM IDLE and ctrl_done=1, gives ctrl_start=1 at T+2.
REQ-032 One job is in flight at a time; back-to-back jobs need at least one IDLE cycle between RESPOND and the next LAUNCH.

Reset
REQ-033 Reset sets the FSM to IDLE, empties the queue, and clears the counter and err.
REQ-034 During and after reset until the next dispatch: req_ready=1 after reset release, ctrl_start=0, ctrl_mod_idx=0, rsp_valid=0, rsp_tag=0, rsp_err=0, rsp_cycles=0, busy=0.
REQ-035 Reset mid-job drops the queued and in-flight jobs with no response; the controller is reset by the same reset.

Structure
REQ-036 The shared package holds the FSM state encoding, MAX_MOD_IDX, and the rsp_cycles width constant.
REQ-037 The queue is one sub-module, ntt_job_fifo, parameterised by depth and width; the FSM and counter stay in the top module.

Verification
REQ-038 Reset: hold reset 3 cycles, then push mod_idx=5, tag=3 at T; expect ctrl_start at T+2, ctrl_mod_idx=5 held; done-model low for 100 cycles; expect rsp_valid with tag=3, err=0, cycles=102.
REQ-039 Illegal index: push mod_idx=60; expect no ctrl_start and a response with err=1, cycles=0.
REQ-040 Start timeout: done-model ignores start; expect a response with err=1, cycles=5 (LAUNCH plus 4 WAIT_BUSY cycles).
REQ-041 Queue full: push 5 jobs back-to-back while the controller runs; expect req_ready=0 after 4 entries, then responses in order of tags 0..3 and the 5th accepted after the first pop.
REQ-042 Backpressure: hold rsp_ready=0 for 10 cycles; expect rsp_* stable and no new ctrl_start until the handshake.
REQ-043 Reset mid-RUN: expect all outputs at reset values the next cycle and no stale response afterwards.

Source files
------------

// File: rtl/ntt_job_scheduler_pkg.sv
// ntt_job_scheduler_pkg: shared FSM encoding and width constants for the NTT job scheduler
package ntt_job_scheduler_pkg;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, RESPOND} state_t;
  localparam int DEFAULT_MAX_MOD_IDX = 59;
  localparam int CYCLES_W = 20;
  localparam int MOD_W = 6;
  localparam int TAG_W = 4;
endpackage

// File: rtl/ntt_job_fifo.sv
// ntt_job_fifo: job queue (FIFO) with full/empty flags
// Ports: clk, reset (sync, active-high), push/din write side, pop/dout read side (dout shows the head), full, empty.
module ntt_job_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rd];
  always_ff @(posedge clk)
    if (do_push) mem[wr] <= din;
  always_ff @(posedge clk)
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/ntt_job_scheduler.sv
// ntt_job_scheduler: queues NTT jobs and dispatches them one at a time to the NTT controller
// Ports: req_* job request in, ctrl_* controller start/index/idle, rsp_* completion out, busy status.
module ntt_job_scheduler import ntt_job_scheduler_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_MOD_IDX = DEFAULT_MAX_MOD_IDX,
  parameter int START_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MOD_W-1:0]    req_mod_idx,
  input  logic [TAG_W-1:0]    req_tag,
  output logic                ctrl_start,
  output logic [MOD_W-1:0]    ctrl_mod_idx,
  input  logic                ctrl_done,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [TAG_W-1:0]    rsp_tag,
  output logic                rsp_err,
  output logic [CYCLES_W-1:0] rsp_cycles,
  output logic                busy
);
  localparam logic [MOD_W-1:0] MAX_IDX = MOD_W'(MAX_MOD_IDX);
  localparam logic [CYCLES_W-1:0] TIMEOUT_CNT = CYCLES_W'(START_TIMEOUT);
  state_t state;
  logic [TAG_W+MOD_W-1:0] head;
  logic [CYCLES_W-1:0] cnt;
  logic [TAG_W-1:0] tag;
  logic err, empty, full, dispatch;
  assign req_ready = !full;
  assign dispatch = state == IDLE && !empty && ctrl_done;
  assign busy = state != IDLE || !empty;
  assign rsp_tag = tag;
  assign rsp_err = err;
  assign rsp_cycles = cnt;
  ntt_job_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(TAG_W + MOD_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(req_valid && req_ready),
    .pop(dispatch),
    .din({req_tag, req_mod_idx}),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tag <= '0;
      err <= 1'b0;
      ctrl_start <= 1'b0;
      ctrl_mod_idx <= '0;
      rsp_valid <= 1'b0;
    end else begin
      ctrl_start <= 1'b0;
      if ((state == LAUNCH || state == WAIT_BUSY || state == RUN) && cnt != '1) cnt <= cnt + 1'b1;
      case (state)
        IDLE:
          if (dispatch) begin
            tag <= head[TAG_W+MOD_W-1:MOD_W];
            cnt <= '0;
            if (head[MOD_W-1:0] > MAX_IDX) begin
              err <= 1'b1;
              rsp_valid <= 1'b1;
              state <= RESPOND;
            end else begin
              ctrl_mod_idx <= head[MOD_W-1:0];
              ctrl_start <= 1'b1;
              state <= LAUNCH;
            end
          end
        LAUNCH: state <= WAIT_BUSY;
        // cnt is 1 on the first WAIT_BUSY cycle, so cnt==START_TIMEOUT marks the last allowed one
        WAIT_BUSY:
          if (!ctrl_done) state <= RUN;
          else if (cnt == TIMEOUT_CNT) begin
            err <= 1'b1;
            rsp_valid <= 1'b1;
            state <= RESPOND;
          end
        RUN:
          if (ctrl_done) begin
            rsp_valid <= 1'b1;
            state <= RESPOND;
          end
        RESPOND:
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            err <= 1'b0;
            state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ntt_job_scheduler.sv
// tb_ntt_job_scheduler: directed self-checking bench for ntt_job_scheduler
module tb_ntt_job_scheduler;
  logic clk = 1'b0, reset = 1'b1, req_valid = 1'b0, rsp_ready = 1'b0;
  logic [5:0] req_mod_idx = '0;
  logic [3:0] req_tag = '0;
  logic req_ready, ctrl_start, ctrl_done, rsp_valid, rsp_err, busy;
  logic [5:0] ctrl_mod_idx;
  logic [3:0] rsp_tag;
  logic [19:0] rsp_cycles;
  int checks = 0, errors = 0, starts = 0, rsp_seen = 0;
  int done_cnt = 0, run_len = 0, s0, r0;
  logic model_en = 1'b1, ext_busy = 1'b0;

  ntt_job_scheduler dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_mod_idx(req_mod_idx), .req_tag(req_tag),
    .ctrl_start(ctrl_start), .ctrl_mod_idx(ctrl_mod_idx), .ctrl_done(ctrl_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .rsp_cycles(rsp_cycles), .busy(busy)
  );

  always #5 clk = ~clk;

  // controller model: after a start it drops done for run_len cycles; ext_busy holds it busy
  assign ctrl_done = !ext_busy && done_cnt == 0;
  always @(posedge clk) begin
    if (reset) done_cnt <= 0;
    else if (ctrl_start && model_en) done_cnt <= run_len;
    else if (done_cnt != 0) done_cnt <= done_cnt - 1;
    if (!reset && ctrl_start) starts <= starts + 1;
    if (!reset && rsp_valid) rsp_seen <= rsp_seen + 1;
  end

  task chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task push(input logic [3:0] t, input logic [5:0] m);
    int n;
    req_valid = 1'b1;
    req_tag = t;
    req_mod_idx = m;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task get_rsp(input logic [3:0] t, input logic e, input int c);
    int n;
    n = 0;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_tag", rsp_tag, t);
    chk("rsp_err", rsp_err, e);
    chk("rsp_cycles", rsp_cycles, c);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_valid_clear", rsp_valid, 0);
    chk("rsp_err_clear", rsp_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctrl_start", ctrl_start, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ctrl_mod_idx", ctrl_mod_idx, 0);
    chk("rst_rsp_tag", rsp_tag, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_cycles", rsp_cycles, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);

    // basic job: start two cycles after push, 100-cycle run gives 102
    run_len = 100;
    s0 = starts;
    push(4'd3, 6'd5);
    chk("lat_no_start_t1", ctrl_start, 0);
    @(negedge clk);
    chk("lat_start_t2", ctrl_start, 1);
    chk("lat_mod_idx", ctrl_mod_idx, 5);
    @(negedge clk);
    chk("start_one_cycle", ctrl_start, 0);
    chk("busy_running", busy, 1);
    get_rsp(4'd3, 1'b0, 102);
    chk("mod_idx_held", ctrl_mod_idx, 5);
    chk("one_start", starts - s0, 1);

    // illegal modulus index
    s0 = starts;
    push(4'd1, 6'd60);
    get_rsp(4'd1, 1'b1, 0);
    chk("illegal_no_start", starts - s0, 0);
    chk("illegal_mod_unchanged", ctrl_mod_idx, 5);

    // start timeout: controller ignores start
    model_en = 1'b0;
    push(4'd2, 6'd7);
    get_rsp(4'd2, 1'b1, 5);
    model_en = 1'b1;

    // queue full while controller reports busy
    ext_busy = 1'b1;
    run_len = 2;
    s0 = starts;
    for (int i = 0; i < 4; i++) push(4'(i), 6'(10 + i));
    chk("full_not_ready", req_ready, 0);
    chk("full_busy", busy, 1);
    req_valid = 1'b1;
    req_tag = 4'd4;
    req_mod_idx = 6'd14;
    repeat (3) @(negedge clk);
    chk("full_still_blocked", req_ready, 0);
    chk("full_no_start", starts - s0, 0);
    ext_busy = 1'b0;
    @(negedge clk);
    chk("pop_frees_slot", req_ready, 1);
    chk("pop_launch", ctrl_start, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("full_again", req_ready, 0);
    for (int i = 0; i < 5; i++) get_rsp(4'(i), 1'b0, 4);
    chk("queue_drained", busy, 0);

    // response backpressure
    run_len = 3;
    push(4'd6, 6'd20);
    push(4'd7, 6'd21);
    for (int n = 0; n < 100 && !rsp_valid; n++) @(negedge clk);
    s0 = starts;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_tag", rsp_tag, 6);
      chk("bp_cycles", rsp_cycles, 5);
    end
    chk("bp_no_start", starts - s0, 0);
    get_rsp(4'd6, 1'b0, 5);
    get_rsp(4'd7, 1'b0, 5);
    chk("bp_second_mod", ctrl_mod_idx, 21);

    // reset during RUN drops everything
    run_len = 50;
    push(4'd9, 6'd30);
    push(4'd10, 6'd31);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mr_rsp_valid", rsp_valid, 0);
    chk("mr_ctrl_start", ctrl_start, 0);
    chk("mr_ctrl_mod_idx", ctrl_mod_idx, 0);
    chk("mr_rsp_tag", rsp_tag, 0);
    chk("mr_rsp_err", rsp_err, 0);
    chk("mr_rsp_cycles", rsp_cycles, 0);
    chk("mr_busy", busy, 0);
    chk("mr_req_ready", req_ready, 1);
    reset = 1'b0;
    s0 = starts;
    r0 = rsp_seen;
    repeat (80) @(negedge clk);
    chk("mr_no_stale_rsp", rsp_seen - r0, 0);
    chk("mr_no_stale_start", starts - s0, 0);
    chk("mr_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
